decoder_nbit_reg: RTL and testbench
===================================

# decoder_nbit_reg

Parametrised, registered binary-to-one-hot decoder, the successor to the 2-to-4 combinational decoder. It generalises the select width to N bits and registers the output behind a valid/ready input handshake. It adds hold and single-cycle pulse output modes and an optional auto-scan mode. It sits between control logic and one-hot consumers such as chip selects, digit enables, row strobes and interrupt fan-out.

## Interface
- N, default 2: select width; output width is 2^N; legal range 1..6.
- DWELL, default 4: cycles each index is held in scan mode; must be ≥ 1.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; low forces the output off.
- sel_valid  input  1  sel is presented.
- sel  input  N  binary index to decode.
- sel_ready  output  1  block accepts sel this cycle.
- mode  input  1  0 = hold, 1 = pulse; sampled at accept.
- scan  input  1  start/continue auto-scan; present only with DECODER_SCAN_EN.
- Y  output  2^N  one-hot (or all-zero) registered output.
- y_valid  output  1  Y carries a decoded index.
- out_idx  output  N  binary index currently driven on Y.

## Operation
- States: IDLE, HOLD, PULSE, SCAN.
- Reset state is IDLE. Output reset values: Y = 0, y_valid = 0, out_idx = 0, sel_ready = 0 during rst. sel_ready = en the cycle after rst drops.
- sel_ready = en AND state ≠ SCAN AND NOT scan-request. It is combinational from state and inputs; it never depends on sel_valid.
- Accept = sel_valid & sel_ready. On accept:
  - Y ← 1 << sel, out_idx ← sel, y_valid ← 1.
  - Next state is HOLD (mode = 0) or PULSE (mode = 1).
- HOLD: Y is stable until the next accept (re-decode) or en = 0. On en = 0: Y ← 0, y_valid ← 0, state → IDLE.
- PULSE: Y is asserted for exactly one cycle. With no accept in that cycle: Y ← 0, y_valid ← 0, state → IDLE. An accept during PULSE produces back-to-back decodes, one per cycle.
- Y is always zero or exactly one-hot, never multi-hot. y_valid = (Y ≠ 0) at all times.
- out_idx holds its last value when y_valid = 0.
- Mid-operation rst: returns to the reset values on the next edge, overriding all other inputs.

## Timing
- Latency from accept to Y: 1 cycle. Throughput: 1 decode per cycle.
- Drop on en = 0: Y clears on the first edge where en is sampled low.
- Simultaneous en = 0 and sel_valid: no accept (sel_ready = 0), Y clears.
- Simultaneous scan and sel_valid (macro on): scan wins and sel is not accepted.
- Scan start: the first edge with scan & en gives Y = 1 (index 0).
- Scan step: each index is held DWELL cycles. Index 2^N−1 wraps to 0.
- Scan stop (scan = 0 or en = 0): Y ← 0 and state → IDLE on the next edge. A partial dwell is abandoned and the dwell counter clears.

## Configuration
- DECODER_SCAN_EN defined: the scan port, the SCAN state and the dwell counter (width clog2(DWELL+1)) exist.
- DECODER_SCAN_EN not defined: no scan port and no SCAN state. sel_ready = en. DWELL is ignored. All other behaviour is identical.

## Structure
- Shared package decoder_pkg holds:
  - the state enum (IDLE, HOLD, PULSE, SCAN);
  - the MODE_HOLD/MODE_PULSE constants;
  - a function onehot(idx) returning 1 << idx at width 2^N.
- One natural sub-module: decoder_scan_ctr, the dwell counter plus index counter with a wrap output. It is instantiated only under DECODER_SCAN_EN.

## Test plan
- Reset, then N = 2, mode = 0, accept sel = 2 → next cycle Y = 0100, y_valid = 1, out_idx = 2; Y is unchanged 10 cycles later.
- Hold, then accept sel = 3 → Y = 1000 one cycle later. Then en = 0 → Y = 0000, y_valid = 0 on the next edge.
- mode = 1, sel = 0,1,1 on consecutive cycles → Y = 0001, 0010, 0010, then 0000. Y is never multi-hot.
- N = 3, scan = 1, DWELL = 2 → Y walks 0x01,0x01,0x02,0x02,…,0x80,0x80,0x01. sel_ready = 0 throughout.
- scan and sel_valid (sel = 5) asserted in the same cycle → scan starts at index 0 and sel is not accepted. Deassert scan mid-dwell → Y = 0 on the next edge.
- rst asserted during HOLD with Y = 0010 → Y = 0, y_valid = 0, out_idx = 0 on the next edge. sel_ready = 0 while rst is high.

Source files
------------

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the registered N-bit one-hot decoder:
//   - state_e     : controller states (IDLE, HOLD, PULSE, SCAN)
//   - MODE_HOLD / MODE_PULSE : values of the mode input sampled at accept
//   - onehot()    : 1 << idx at the widest supported output width (2^MAX_N);
//                   callers truncate to their own 2^N width.
// No ports (package).
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int MAX_N = 6;
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2,
        SCAN  = 2'd3
    } state_e;

    localparam logic MODE_HOLD  = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] idx);
        return {{(MAX_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/decoder_nbit_reg_scan_ctr.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctr
// Dwell counter plus index counter for the decoder's auto-scan mode.
// Only instantiated when DECODER_SCAN_EN is defined.
// While run_i is high the dwell counter advances each cycle; when it has
// spent DWELL cycles on an index, step_o pulses and the index advances,
// wrapping from 2^N-1 back to 0 (wrap_o). While run_i is low both counters
// are held cleared, so a new scan always begins at index 0 with a fresh dwell.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   run_i  : scan is continuing this cycle
//   idx_o  : current scan index (registered)
//   step_o : index advances on the coming edge
//   wrap_o : index advances from 2^N-1 to 0 on the coming edge
// -----------------------------------------------------------------------------
module decoder_scan_ctr #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         run_i,
    output logic [N-1:0] idx_o,
    output logic         step_o,
    output logic         wrap_o
);

    localparam int             CW      = $clog2(DWELL + 1);
    localparam logic [CW-1:0]  LAST    = CW'(DWELL - 1);
    localparam logic [N-1:0]   IDX_MAX = {N{1'b1}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  idx_q, idx_d;

    assign step_o = run_i & (cnt_q == LAST);
    assign wrap_o = step_o & (idx_q == IDX_MAX);
    assign idx_o  = idx_q;

    // Next-state logic for the dwell and index counters
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!run_i) begin
            cnt_d = {CW{1'b0}};
            idx_d = {N{1'b0}};
        end else if (step_o) begin
            cnt_d = {CW{1'b0}};
            idx_d = wrap_o ? {N{1'b0}} : idx_q + N'(1'b1);
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
            idx_d = idx_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
            idx_q <= {N{1'b0}};
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/decoder_nbit_reg.sv
// -----------------------------------------------------------------------------
// decoder_nbit_reg
// Registered binary-to-one-hot decoder with a valid/ready input handshake,
// hold and single-cycle pulse output modes, and optional auto-scan.
// Optional feature macro: DECODER_SCAN_EN (adds scan_i, the SCAN state and
// the dwell/index counter sub-module).
// Parameters:
//   N     : select width (1..6); output width is 2^N
//   DWELL : cycles per index in scan mode (>= 1); unused without scan
// Ports:
//   clk_i       : rising-edge clock
//   rst_i       : synchronous active-high reset
//   en_i        : block enable; low clears the output
//   sel_valid_i : sel_i is presented
//   sel_i       : binary index to decode
//   mode_i      : 0 = hold, 1 = pulse; sampled at accept
//   scan_i      : start/continue auto-scan (DECODER_SCAN_EN only)
//   sel_ready_o : sel_i is accepted this cycle if sel_valid_i is high
//   y_o         : registered one-hot (or all-zero) output
//   y_valid_o   : y_o carries a decoded index
//   out_idx_o   : binary index last driven on y_o (holds when y_valid_o = 0)
// -----------------------------------------------------------------------------
module decoder_nbit_reg
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                sel_valid_i,
    input  logic [N-1:0]        sel_i,
    input  logic                mode_i,
`ifdef DECODER_SCAN_EN
    input  logic                scan_i,
`endif
    output logic                sel_ready_o,
    output logic [(1<<N)-1:0]   y_o,
    output logic                y_valid_o,
    output logic [N-1:0]        out_idx_o
);

    localparam int W = 1 << N;

    if (N < 1 || N > MAX_N || DWELL < 1) begin : g_param_check
        $error("decoder_nbit_reg: N must be 1..6 and DWELL >= 1");
    end

    state_e         state_q, state_d;
    logic [W-1:0]   y_q, y_d;
    logic           y_valid_q, y_valid_d;
    logic [N-1:0]   idx_q, idx_d;

    logic           accept_s;
    logic           load_s;
    logic           clear_s;
    logic [N-1:0]   dec_idx_s;

`ifdef DECODER_SCAN_EN
    logic           scan_req_s;
    logic           scan_run_s;
    logic           scan_step_s;
    logic           scan_wrap_s;
    logic [N-1:0]   scan_idx_s;

    assign scan_req_s = en_i & scan_i;
    // Already scanning and asked to keep going: the counters advance.
    assign scan_run_s = scan_req_s & (state_q == SCAN);

    decoder_scan_ctr #(
        .N     (N),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run_i  (scan_run_s),
        .idx_o  (scan_idx_s),
        .step_o (scan_step_s),
        .wrap_o (scan_wrap_s)
    );

    // A scan request always beats a presented sel.
    assign sel_ready_o = en_i & ~rst_i & (state_q != SCAN) & ~scan_i;
`else
    assign sel_ready_o = en_i & ~rst_i;
`endif

    assign accept_s = sel_valid_i & sel_ready_o;

    // Next-state, next-output decision for the controller
    always_comb begin
        state_d   = state_q;
        load_s    = 1'b0;
        clear_s   = 1'b0;
        dec_idx_s = sel_i;
`ifdef DECODER_SCAN_EN
        if (scan_req_s) begin
            state_d = SCAN;
            load_s  = 1'b1;
            if (!scan_run_s) begin
                dec_idx_s = {N{1'b0}};           // first scan edge shows index 0
            end else if (scan_wrap_s) begin
                dec_idx_s = {N{1'b0}};
            end else if (scan_step_s) begin
                dec_idx_s = scan_idx_s + N'(1'b1);
            end else begin
                dec_idx_s = scan_idx_s;
            end
        end else if (state_q == SCAN) begin
            state_d = IDLE;
            clear_s = 1'b1;
        end else
`endif
        if (!en_i) begin
            state_d = IDLE;
            clear_s = 1'b1;
        end else if (accept_s) begin
            load_s = 1'b1;
            case (mode_i)
                MODE_HOLD:  state_d = HOLD;
                MODE_PULSE: state_d = PULSE;
                default:    state_d = HOLD;
            endcase
        end else if (state_q == PULSE) begin
            state_d = IDLE;
            clear_s = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // Output register next values derived from load/clear decisions
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        idx_d     = idx_q;
        if (load_s) begin
            y_d       = W'(onehot(MAX_N'(dec_idx_s)));
            y_valid_d = 1'b1;
            idx_d     = dec_idx_s;
        end else if (clear_s) begin
            y_d       = {W{1'b0}};
            y_valid_d = 1'b0;
            idx_d     = idx_q;                   // index survives the clear
        end else begin
            y_d       = y_q;
            y_valid_d = y_valid_q;
            idx_d     = idx_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            y_q       <= {W{1'b0}};
            y_valid_q <= 1'b0;
            idx_q     <= {N{1'b0}};
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            idx_q     <= idx_d;
        end
    end

    assign y_o       = y_q;
    assign y_valid_o = y_valid_q;
    assign out_idx_o = idx_q;

endmodule

// File: tb/tb_decoder_nbit_reg.sv
// -----------------------------------------------------------------------------
// tb_decoder_nbit_reg
// Self-checking bench for decoder_nbit_reg (N = 3, DWELL = 2). A behavioural
// model tracks "is an index shown, which one, was it a pulse, how long has
// the scan been running" and is compared against the DUT every cycle;
// directed sequences add literal expectations, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_decoder_nbit_reg;

    localparam int N     = 3;
    localparam int DWELL = 2;
    localparam int W     = 1 << N;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN_BUILT = 1'b1;
`else
    localparam bit SCAN_BUILT = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         en        = 1'b0;
    logic         sel_valid = 1'b0;
    logic         mode      = 1'b0;
    logic         scan      = 1'b0;
    logic [N-1:0] sel       = '0;

    logic         sel_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic [N-1:0] out_idx;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit m_valid = 1'b0;
    bit m_pulse = 1'b0;
    bit m_scan  = 1'b0;
    int m_idx   = 0;
    int m_age   = 0;

    decoder_nbit_reg #(
        .N     (N),
        .DWELL (DWELL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .sel_valid_i (sel_valid),
        .sel_i       (sel),
        .mode_i      (mode),
`ifdef DECODER_SCAN_EN
        .scan_i      (scan),
`endif
        .sel_ready_o (sel_ready),
        .y_o         (y),
        .y_valid_o   (y_valid),
        .out_idx_o   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the outputs must be after this edge, from the rules.
    task automatic model_edge();
        bit go;
        go = SCAN_BUILT && scan && en;
        if (rst) begin
            m_valid = 1'b0; m_pulse = 1'b0; m_scan = 1'b0; m_idx = 0; m_age = 0;
        end else if (go) begin
            if (m_scan) m_age = m_age + 1;
            else        m_age = 0;
            m_scan  = 1'b1;
            m_valid = 1'b1;
            m_pulse = 1'b0;
            m_idx   = (m_age / DWELL) % W;
        end else if (m_scan) begin
            m_scan = 1'b0; m_valid = 1'b0; m_age = 0;
        end else if (!en) begin
            m_valid = 1'b0; m_pulse = 1'b0;
        end else if (sel_valid) begin
            m_valid = 1'b1; m_idx = int'(sel); m_pulse = mode;
        end else if (m_pulse) begin
            m_valid = 1'b0; m_pulse = 1'b0;
        end
    endtask

    task automatic compare();
        logic [W-1:0] ey;
        logic         erdy;
        ey = '0;
        if (m_valid) ey[m_idx] = 1'b1;
        erdy = en && !rst && !(SCAN_BUILT && (m_scan || scan));
        chk("y",         64'(y),         64'(ey));
        chk("y_valid",   64'(y_valid),   64'(m_valid));
        chk("out_idx",   64'(out_idx),   64'(m_idx));
        chk("sel_ready", 64'(sel_ready), 64'(erdy));
        chk("onehot",    64'($countones(y) <= 1), 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    logic [W-1:0] scan_walk [18] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04,
                                     8'h08, 8'h08, 8'h10, 8'h10, 8'h20, 8'h20,
                                     8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01};

    initial begin
        // reset
        rst = 1'b1; en = 1'b1;
        tick(); tick();
        chk("rst_ready", 64'(sel_ready), 64'd0);
        chk("rst_y",     64'(y),         64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(sel_ready), 64'd1);
        tick();

        // hold decode of 2, stable for 10 cycles
        sel = 3'd2; mode = 1'b0; sel_valid = 1'b1;
        tick();
        chk("hold2_y",   64'(y),       64'h04);
        chk("hold2_idx", 64'(out_idx), 64'd2);
        chk("hold2_vld", 64'(y_valid), 64'd1);
        sel_valid = 1'b0;
        repeat (10) tick();
        chk("hold2_stable", 64'(y), 64'h04);

        // re-decode 3, then drop enable
        sel = 3'd3; sel_valid = 1'b1;
        tick();
        chk("hold3_y", 64'(y), 64'h08);
        sel_valid = 1'b0; en = 1'b0;
        tick();
        chk("en_off_y",   64'(y),       64'h00);
        chk("en_off_vld", 64'(y_valid), 64'd0);
        chk("en_off_idx", 64'(out_idx), 64'd3);
        en = 1'b1;

        // pulse mode 0,1,1 back to back
        mode = 1'b1; sel_valid = 1'b1; sel = 3'd0;
        tick(); chk("pulse0", 64'(y), 64'h01);
        sel = 3'd1;
        tick(); chk("pulse1a", 64'(y), 64'h02);
        tick(); chk("pulse1b", 64'(y), 64'h02);
        sel_valid = 1'b0;
        tick(); chk("pulse_end", 64'(y), 64'h00);

        // en low with sel_valid: no accept
        en = 1'b0; sel_valid = 1'b1; sel = 3'd4; mode = 1'b0;
        tick(); chk("en_low_valid", 64'(y), 64'h00);
        en = 1'b1; sel_valid = 1'b0;

        // reset during hold
        sel = 3'd1; sel_valid = 1'b1;
        tick(); chk("hold1_y", 64'(y), 64'h02);
        sel_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(sel_ready), 64'd0);
        tick();
        chk("rst_mid_y",   64'(y),       64'h00);
        chk("rst_mid_vld", 64'(y_valid), 64'd0);
        chk("rst_mid_idx", 64'(out_idx), 64'd0);
        rst = 1'b0;
        tick();

`ifdef DECODER_SCAN_EN
        // scan beats sel, walks every index for DWELL cycles, then stops mid-dwell
        scan = 1'b1; sel_valid = 1'b1; sel = 3'd5;
        for (int k = 0; k < 18; k++) begin
            tick();
            chk("scan_walk", 64'(y), 64'(scan_walk[k]));
            chk("scan_ready", 64'(sel_ready), 64'd0);
        end
        sel_valid = 1'b0;
        tick();
        chk("scan_mid", 64'(y), 64'h02);
        scan = 1'b0;
        tick();
        chk("scan_stop", 64'(y), 64'h00);
        scan = 1'b1;
        tick();
        chk("scan_restart", 64'(y), 64'h01);
        scan = 1'b0;
        tick();
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            en        = ($urandom_range(0, 7) != 0);
            sel_valid = $urandom_range(0, 1) == 1;
            sel       = N'($urandom);
            mode      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) scan = ~scan;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
